// File: rtl/sin_acq_ctrl.sv
// sin_acq_ctrl - acquisition sequencer for the sine test-signal generator and ADC.
//   Runs IDLE -> ARM -> RUN -> DRAIN -> FIN. In RUN it drives the generator's
//   sample_clk strobe, counts generator periods and turns each start_conv rise into
//   an adc_req/adc_ack handshake. A run ends after n_periods periods or on stop.
// Optional feature: define ADC_TIMEOUT_EN to drop an unacknowledged request after
//   TO_CYC cycles and flag it in err[1]. Without it err[1] is always 0.
module sin_acq_ctrl #(
    parameter int DIV_W  = 16,
    parameter int PER_W  = 8,
    parameter int CNT_W  = 16,
    parameter int TO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [PER_W-1:0] n_periods,
    output logic             gen_rst,
    output logic             gen_en,
    output logic             sample_clk,
    input  logic             new_period,
    input  logic             start_conv,
    input  logic             phaze,
    output logic             adc_req,
    input  logic             adc_ack,
    output logic             adc_phaze,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] conv_cnt,
    output logic [1:0]       err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_lat;     // divider setting frozen for the whole run
    logic [DIV_W-1:0] div_cnt;
    logic [PER_W-1:0] n_lat;       // period target frozen for the whole run
    logic [PER_W-1:0] per_cnt;
    logic             arm_cnt;     // ARM lasts exactly two cycles
    logic             first_seen;  // first new_period rise after ARM has occurred
    logic             np_prev;
    logic             sc_prev;

    logic             np_rise;
    logic             sc_rise;
    logic             term_edge;
    logic             conv_rise;
    logic             to_hit;
    logic             err_ovr;
    logic             err_to;

    assign np_rise = new_period & ~np_prev;
    assign sc_rise = start_conv & ~sc_prev;

    // The first period rise only marks the start of the first period; the run ends on
    // the rise that completes period n_lat. n_lat == 0 means run until stop.
    assign term_edge = (state == RUN) && np_rise && first_seen && (n_lat != '0) &&
                       ((per_cnt + PER_W'(1)) == n_lat);

    // A conversion request coincident with the terminating period edge belongs to a
    // period that will never be sampled, so it is ignored.
    assign conv_rise = (state == RUN) && sc_rise && !term_edge;

    assign err = {err_to, err_ovr};

`ifdef ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    // A request that has been held TO_CYC cycles without ack is given up this edge.
    assign to_hit = adc_req && !adc_ack && (to_cnt == TO_W'(TO_CYC - 1));
`else
    assign to_hit = 1'b0;
    assign err_to = 1'b0;
`endif

    // Sequencer FSM: state, generator controls, sample_clk divider and period counting.
    // NOTE: every register in a clocked block uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gen_rst    <= 1'b0;
            gen_en     <= 1'b0;
            sample_clk <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_lat    <= '0;
            div_cnt    <= '0;
            n_lat      <= '0;
            per_cnt    <= '0;
            arm_cnt    <= 1'b0;
            first_seen <= 1'b0;
            np_prev    <= 1'b0;
            sc_prev    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_lat <= div;
                        n_lat   <= n_periods;
                        arm_cnt <= 1'b0;
                        gen_rst <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ARM;
                    end
                end

                ARM: begin
                    // Generator is released from reset and settles at count 0 here;
                    // everything that tracks it restarts from a clean slate.
                    np_prev    <= 1'b0;
                    sc_prev    <= 1'b0;
                    div_cnt    <= '0;
                    per_cnt    <= '0;
                    first_seen <= 1'b0;
                    sample_clk <= 1'b0;
                    if (arm_cnt) begin
                        gen_en <= 1'b1;
                        state  <= RUN;
                    end else begin
                        arm_cnt <= 1'b1;
                    end
                end

                RUN: begin
                    np_prev <= new_period;
                    sc_prev <= start_conv;

                    // Half-period divider: toggle the strobe every div_lat+1 cycles.
                    if (div_cnt == div_lat) begin
                        div_cnt    <= '0;
                        sample_clk <= ~sample_clk;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end

                    if (np_rise) begin
                        if (!first_seen) begin
                            first_seen <= 1'b1;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end

                    // stop and the terminal edge may coincide; either way one exit.
                    if (stop || term_edge) begin
                        gen_en     <= 1'b0;
                        sample_clk <= 1'b0;
                        state      <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Generator is frozen; wait for the outstanding request to finish.
                    if (!adc_req) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    gen_rst <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    gen_rst    <= 1'b0;
                    gen_en     <= 1'b0;
                    sample_clk <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Conversion channel: issue a request per start_conv rise, retire it on ack,
    // count completions and keep sticky error flags for the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc_req   <= 1'b0;
            adc_phaze <= 1'b0;
            conv_cnt  <= '0;
            err_ovr   <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            to_cnt    <= '0;
            err_to    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                conv_cnt <= '0;
                err_ovr  <= 1'b0;
`ifdef ADC_TIMEOUT_EN
                err_to   <= 1'b0;
`endif
            end
        end else begin
            if (adc_req && adc_ack) begin
                adc_req <= 1'b0;
                if (conv_cnt != '1) begin
                    conv_cnt <= conv_cnt + CNT_W'(1);
                end
`ifdef ADC_TIMEOUT_EN
            end else if (to_hit) begin
                adc_req <= 1'b0;
                err_to  <= 1'b1;
            end else if (adc_req) begin
                to_cnt <= to_cnt + TO_W'(1);
`endif
            end

            // A request retiring on this same edge frees the channel for the new one;
            // otherwise the new rise is an overrun and the pending request keeps going.
            if (conv_rise) begin
                if (adc_req && !adc_ack && !to_hit) begin
                    err_ovr <= 1'b1;
                end else begin
                    adc_req   <= 1'b1;
                    adc_phaze <= phaze;
`ifdef ADC_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end
            end
        end
    end

endmodule
